pixel_window_sreg: RTL and testbench
====================================

# pixel_window_sreg

Parametrised pixel window shift register for the digit-recognizer datapath. It generalises the single 8-bit enable-loaded pixel register into a DEPTH-stage chain of PIXEL_W-bit stages. The block tracks how many valid pixels it holds and flags when a complete window is present. It sits between the pixel input path and the feature/compare logic, which reads the whole window in parallel.

## Interface
- PIXEL_W, 8, bits per pixel stage (≥1)
- DEPTH, 4, number of stages in the window (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- shift_en  in  1  shift parallel_in into stage 0 this edge
- clear  in  1  synchronous flush of window contents and fill state
- parallel_in  in  PIXEL_W  incoming pixel
- window_out  out  PIXEL_W*DEPTH  all stages; stage k at bits [k*PIXEL_W +: PIXEL_W]; stage 0 = newest
- oldest_out  out  PIXEL_W  stage DEPTH-1
- fill_count  out  $clog2(DEPTH+1)  valid pixels held, saturates at DEPTH
- full  out  1  fill_count == DEPTH
- window_valid  out  1  one-cycle pulse: a shift just produced a complete window
- window_sum  out  PIXEL_W+$clog2(DEPTH)  sum of all stages (see Configuration)

Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

## Operation
- Priority per edge: rst > clear > shift_en > hold.
- rst or clear: all stages ← 0, fill_count ← 0, window_valid ← 0, window_sum ← 0.
- shift_en=1, no clear: stage0 ← parallel_in, stage k ← stage k-1 for k=1..DEPTH-1, and the previous stage DEPTH-1 is discarded.
  - fill_count ← min(fill_count+1, DEPTH).
  - window_valid ← 1 iff the pre-edge fill_count ≥ DEPTH-1, otherwise 0.
- shift_en=0, no clear: all stages, fill_count and window_sum hold; window_valid ← 0.
- Unfilled stages read 0. This is guaranteed because reset and clear zero every stage.
- full is combinational from fill_count. All other outputs are direct register outputs, with no combinational path from input to output.
- Continuous shifting once full: window_valid stays high every shifting cycle, and fill_count stays at DEPTH (no wrap).
- clear and shift_en together: clear wins and parallel_in is dropped. fill_count=0 and window_valid=0 on the next cycle.

## Timing
- Latency 1: the pixel presented with shift_en at edge N appears in stage 0 after edge N. It reaches oldest_out after edge N+DEPTH-1, assuming DEPTH-1 further shifts.
- window_valid, fill_count and window_sum update on the same edge as the stages and are aligned with the window_out they describe.
- A pixel is lost only by eviction from stage DEPTH-1, or by rst/clear.
- rst mid-fill or mid-stream: the next cycle is identical to the post-reset state, and no stale window_valid appears.

## Configuration
- Macro PIXEL_WINDOW_SUM_EN.
- Defined: window_sum is a register updated incrementally on every shift as window_sum + parallel_in − stage[DEPTH-1] (pre-edge values). It is exact with no overflow at the declared width, and holds when shift_en=0.
- Not defined: the sum register and adder are compiled out and window_sum is tied to 0. All other behaviour is unchanged.

## Test plan
Defaults used: PIXEL_W=8, DEPTH=4.
- Reset, then apply shift_en with pixels 0x11, 0x22, 0x33 -> fill_count 1, 2, 3; full=0; window_valid=0; window_out=0x00112233 (stage3..0); oldest_out=0x00.
- Shift a 4th pixel 0x44 -> full=1, window_valid pulses for 1 cycle, window_out=0x11223344, oldest_out=0x11, window_sum=0xAA (with SUM_EN).
- Shift 0x55 then idle 3 cycles -> window_out=0x22334455, fill_count stays 4, window_valid high for 1 cycle then 0 during idle, window_sum=0xEE held.
- Shift 0xFF on four consecutive edges after clear -> window_sum=0x3FC with no overflow, window_valid high on the 4th shift only.
- Assert clear together with shift_en (parallel_in=0x99) while full -> next cycle all stages 0, fill_count=0, window_valid=0, window_sum=0.
- Assert rst after 2 shifts, then shift 0x01 -> fill_count=1, window_out=0x00000001; without PIXEL_WINDOW_SUM_EN, window_sum stays 0 throughout.

Source files
------------

// File: rtl/pixel_window_sreg.sv
// Pixel window shift register: DEPTH stages of PIXEL_W bits, fill tracking and window-complete pulse.
// Optional running window sum enabled by macro PIXEL_WINDOW_SUM_EN (window_sum tied to 0 otherwise).

module pixel_window_stage #(
  parameter int PIXEL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [PIXEL_W-1:0] i_d,
  output logic [PIXEL_W-1:0] o_q
);
  logic [PIXEL_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clear) r_q <= '0;
    else if (shift_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module pixel_window_sreg #(
  parameter int PIXEL_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               shift_en,
  input  logic                               clear,
  input  logic [PIXEL_W-1:0]                 parallel_in,
  output logic [PIXEL_W*DEPTH-1:0]           window_out,
  output logic [PIXEL_W-1:0]                 oldest_out,
  output logic [$clog2(DEPTH+1)-1:0]         fill_count,
  output logic                               full,
  output logic                               window_valid,
  output logic [PIXEL_W+$clog2(DEPTH)-1:0]   window_sum
);
  localparam int FW = $clog2(DEPTH+1);
  localparam int SW = PIXEL_W + $clog2(DEPTH);
  localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);

  logic [DEPTH-1:0][PIXEL_W-1:0] r_stage;
  logic [DEPTH-1:0][PIXEL_W-1:0] w_stage_d;
  logic [FW-1:0]                 r_fill;
  logic                          r_valid;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_stage_d[k] = parallel_in;
      end else begin : g_body
        assign w_stage_d[k] = r_stage[k-1];
      end
      pixel_window_stage #(.PIXEL_W(PIXEL_W)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (shift_en),
        .i_d      (w_stage_d[k]),
        .o_q      (r_stage[k])
      );
    end
  endgenerate

  // Valid pulses on the shift that completes (or keeps) a full window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else if (shift_en) begin
      if (r_fill != DEPTH_C) r_fill <= r_fill + FW'(1);
      r_valid <= (r_fill >= DEPTH_C - FW'(1));
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef PIXEL_WINDOW_SUM_EN
  logic [SW-1:0] r_sum;

  // Incremental update stays exact: true sum never exceeds DEPTH*(2^PIXEL_W-1).
  always_ff @(posedge clk) begin
    if (rst || clear) r_sum <= '0;
    else if (shift_en) r_sum <= r_sum + SW'(parallel_in) - SW'(r_stage[DEPTH-1]);
  end

  assign window_sum = r_sum;
`else
  assign window_sum = '0;
`endif

  assign window_out   = r_stage;
  assign oldest_out   = r_stage[DEPTH-1];
  assign fill_count   = r_fill;
  assign full         = (r_fill == DEPTH_C);
  assign window_valid = r_valid;
endmodule

// File: tb/tb_pixel_window_sreg.sv
// Directed vector bench for pixel_window_sreg (PIXEL_W=8, DEPTH=4); sum checks follow PIXEL_WINDOW_SUM_EN.
module tb_pixel_window_sreg;
  logic        clk = 1'b0;
  logic        rst, shift_en, clear;
  logic [7:0]  parallel_in;
  logic [31:0] window_out;
  logic [7:0]  oldest_out;
  logic [2:0]  fill_count;
  logic        full, window_valid;
  logic [9:0]  window_sum;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pixel_window_sreg #(.PIXEL_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (shift_en),
    .clear        (clear),
    .parallel_in  (parallel_in),
    .window_out   (window_out),
    .oldest_out   (oldest_out),
    .fill_count   (fill_count),
    .full         (full),
    .window_valid (window_valid),
    .window_sum   (window_sum)
  );

  typedef struct {
    logic        rst, clr, sh;
    logic [7:0]  din;
    logic [31:0] win;
    logic [2:0]  fill;
    logic        vld;
    logic [9:0]  sum;
  } vec_t;

  vec_t tv[19];

  function automatic vec_t mk(logic r, logic c, logic s, logic [7:0] d,
                              logic [31:0] w, logic [2:0] f, logic v, logic [9:0] sm);
    vec_t t;
    t.rst = r; t.clr = c; t.sh = s; t.din = d;
    t.win = w; t.fill = f; t.vld = v; t.sum = sm;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic check_all(input int idx, input logic [31:0] w, input logic [2:0] f,
                           input logic v, input logic [9:0] sm);
    logic [9:0] esum;
`ifdef PIXEL_WINDOW_SUM_EN
    esum = sm;
`else
    esum = '0;
`endif
    chk("window_out",   idx, 64'(window_out),   64'(w));
    chk("oldest_out",   idx, 64'(oldest_out),   64'(w[31:24]));
    chk("fill_count",   idx, 64'(fill_count),   64'(f));
    chk("full",         idx, 64'(full),         64'(f == 3'd4));
    chk("window_valid", idx, 64'(window_valid), 64'(v));
    chk("window_sum",   idx, 64'(window_sum),   64'(esum));
  endtask

  task automatic step(input logic r, input logic c, input logic s, input logic [7:0] d);
    rst = r; clear = c; shift_en = s; parallel_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mw;
    logic [2:0]  mf;
    logic        mv;
    logic [9:0]  ms;
    logic [7:0]  px;

    rst = 1'b0; clear = 1'b0; shift_en = 1'b0; parallel_in = '0;

    //           rst  clr  sh   din    window        fill  vld   sum
    tv[0]  = mk(1'b1,1'b0,1'b0,8'h00, 32'h00000000, 3'd0, 1'b0, 10'h000);
    tv[1]  = mk(1'b0,1'b0,1'b1,8'h11, 32'h00000011, 3'd1, 1'b0, 10'h011);
    tv[2]  = mk(1'b0,1'b0,1'b1,8'h22, 32'h00001122, 3'd2, 1'b0, 10'h033);
    tv[3]  = mk(1'b0,1'b0,1'b1,8'h33, 32'h00112233, 3'd3, 1'b0, 10'h066);
    tv[4]  = mk(1'b0,1'b0,1'b1,8'h44, 32'h11223344, 3'd4, 1'b1, 10'h0AA);
    tv[5]  = mk(1'b0,1'b0,1'b1,8'h55, 32'h22334455, 3'd4, 1'b1, 10'h0EE);
    tv[6]  = mk(1'b0,1'b0,1'b0,8'hA5, 32'h22334455, 3'd4, 1'b0, 10'h0EE);
    tv[7]  = mk(1'b0,1'b0,1'b0,8'h5A, 32'h22334455, 3'd4, 1'b0, 10'h0EE);
    tv[8]  = mk(1'b0,1'b0,1'b0,8'h00, 32'h22334455, 3'd4, 1'b0, 10'h0EE);
    tv[9]  = mk(1'b0,1'b1,1'b0,8'h00, 32'h00000000, 3'd0, 1'b0, 10'h000);
    tv[10] = mk(1'b0,1'b0,1'b1,8'hFF, 32'h000000FF, 3'd1, 1'b0, 10'h0FF);
    tv[11] = mk(1'b0,1'b0,1'b1,8'hFF, 32'h0000FFFF, 3'd2, 1'b0, 10'h1FE);
    tv[12] = mk(1'b0,1'b0,1'b1,8'hFF, 32'h00FFFFFF, 3'd3, 1'b0, 10'h2FD);
    tv[13] = mk(1'b0,1'b0,1'b1,8'hFF, 32'hFFFFFFFF, 3'd4, 1'b1, 10'h3FC);
    tv[14] = mk(1'b0,1'b1,1'b1,8'h99, 32'h00000000, 3'd0, 1'b0, 10'h000);
    tv[15] = mk(1'b0,1'b0,1'b1,8'h01, 32'h00000001, 3'd1, 1'b0, 10'h001);
    tv[16] = mk(1'b0,1'b0,1'b1,8'h02, 32'h00000102, 3'd2, 1'b0, 10'h003);
    tv[17] = mk(1'b1,1'b0,1'b1,8'h77, 32'h00000000, 3'd0, 1'b0, 10'h000);
    tv[18] = mk(1'b0,1'b0,1'b1,8'h01, 32'h00000001, 3'd1, 1'b0, 10'h001);

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      step(tv[i].rst, tv[i].clr, tv[i].sh, tv[i].din);
      check_all(i, tv[i].win, tv[i].fill, tv[i].vld, tv[i].sum);
    end

    // Long stream: a small window model checks saturation and back-to-back valid.
    mw = 32'h00000001; mf = 3'd1; ms = 10'h001;
    for (int i = 0; i < 10; i++) begin
      px = 8'(i * 8'h37 + 8'h0D);
      mv = (mf >= 3'd3);
      ms = ms + 10'(px) - 10'(mw[31:24]);
      mw = {mw[23:0], px};
      if (mf != 3'd4) mf = mf + 3'd1;
      step(1'b0, 1'b0, 1'b1, px);
      check_all(100 + i, mw, mf, mv, ms);
    end

    // Hold after a stream, then reset mid-stream clears without a stale pulse.
    step(1'b0, 1'b0, 1'b0, 8'hEE);
    check_all(200, mw, mf, 1'b0, ms);
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    check_all(201, 32'h0, 3'd0, 1'b0, 10'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_all(202, 32'h0, 3'd0, 1'b0, 10'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
